input_capture: RTL and testbench

Input-capture unit: timestamps edges of an external asynchronous signal against an internal free-running N-bit timebase and reports the timestamp plus the elapsed time since the previous edge. It is the measuring counterpart of the output-compare counter. The compare counter generates timed strobes; this block receives strobes or pulses and measures them. Results go to a consumer over a valid/ready handshake.

---
 rtl/input_capture_pkg.sv | 32 +++
 rtl/ic_edge_detect.sv | 98 +++++++++
 rtl/input_capture.sv | 121 ++++++++++++
 tb/tb_input_capture.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_capture_pkg
//  Description : Shared types and constants for the input-capture unit.
//                Edge-select encoding, synchronizer depth, post-reset
//                warm-up length and the edge qualification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_capture_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    localparam int SYNC_STAGES   = 2;
    localparam int WARMUP_CYCLES = 3;

    // True when the level change prev -> lvl is one the selection asks for.
    function automatic logic edge_qualify(edge_sel_e sel, logic lvl, logic prev);
        logic rise;
        logic fall;
        rise = lvl & ~prev;
        fall = ~lvl & prev;
        return ((sel == EDGE_RISE || sel == EDGE_BOTH) && rise) ||
               ((sel == EDGE_FALL || sel == EDGE_BOTH) && fall);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ic_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module      : ic_edge_detect
//  Description : Input conditioning for the input-capture unit.
//                ic_in -> 2-flop synchronizer -> optional stability filter
//                -> history flop. edge_evt pulses for one cycle when the
//                conditioned level differs from the history flop and the
//                change matches edge_sel. Detection is held off for
//                WARMUP_CYCLES cycles after reset release.
//                Optional filter: define IC_GLITCH_FILTER_EN.
//  Ports       : clk, rst_n (sync, active-low), ic_in (async),
//                edge_sel[1:0], edge_evt (one-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module ic_edge_detect
    import input_capture_pkg::*;
#(
    parameter int FILT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ic_in,
    input  logic [1:0] edge_sel,
    output logic       edge_evt
);

`ifdef IC_GLITCH_FILTER_EN
    localparam bit c_FILT_EN = 1'b1;
`else
    localparam bit c_FILT_EN = 1'b0;
`endif
    // Zero length means the filter stage is bypassed.
    localparam int c_FILT_LEN = c_FILT_EN ? FILT : 0;

    localparam int                  c_WARM_W    = $clog2(WARMUP_CYCLES + 1);
    localparam logic [c_WARM_W-1:0] c_WARM_DONE = c_WARM_W'(WARMUP_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_level;
    logic                   r_hist;
    logic [c_WARM_W-1:0]    r_warm;
    logic                   w_armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ic_in};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // The filtered level follows the synchronized input only once the
    // input has shown the new level for c_FILT_LEN consecutive samples.
    if (c_FILT_LEN >= 2) begin : g_filter
        logic       r_filt;
        logic [3:0] r_filt_cnt;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_filt     <= 1'b0;
                r_filt_cnt <= '0;
            end else if (w_sync == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == 4'(c_FILT_LEN - 1)) begin
                r_filt     <= w_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
        end

        assign w_level = r_filt;
    end else begin : g_no_filter
        assign w_level = w_sync;
    end

    // History tracks the level regardless of edge_sel, so switching the
    // selection never manufactures a stale edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= 1'b0;
            r_warm <= '0;
        end else begin
            r_hist <= w_level;
            if (r_warm != c_WARM_DONE) begin
                r_warm <= r_warm + 1'b1;
            end
        end
    end

    assign w_armed  = (r_warm == c_WARM_DONE);
    assign edge_evt = w_armed & edge_qualify(edge_sel_e'(edge_sel), w_level, r_hist);

endmodule
`default_nettype wire

// File: rtl/input_capture.sv
`default_nettype none
// ============================================================================
//  Module      : input_capture
//  Description : Input-capture unit. Timestamps qualified edges of ic_in
//                against a free-running N-bit timebase and reports the
//                timestamp and the period since the previous edge over a
//                valid/ready handshake. Events arriving while a result is
//                held and not accepted are dropped and set sticky ovf.
//                Optional glitch filter: define IC_GLITCH_FILTER_EN.
//  Ports       : clk, rst_n (sync, active-low), en, ic_in, edge_sel[1:0],
//                cap_ready, ovf_clr -> cap_valid, cap_val[N-1:0],
//                cap_period[N-1:0], cap_first, ovf, tb_out[N-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module input_capture
    import input_capture_pkg::*;
#(
    parameter int N    = 8,
    parameter int FILT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ic_in,
    input  logic [1:0]   edge_sel,
    input  logic         cap_ready,
    input  logic         ovf_clr,
    output logic         cap_valid,
    output logic [N-1:0] cap_val,
    output logic [N-1:0] cap_period,
    output logic         cap_first,
    output logic         ovf,
    output logic [N-1:0] tb_out
);

    logic [N-1:0] r_tb;
    logic [N-1:0] r_last_ts;
    logic         r_have_prev;
    logic         r_cap_valid;
    logic [N-1:0] r_cap_val;
    logic [N-1:0] r_cap_period;
    logic         r_cap_first;
    logic         r_ovf;

    logic         w_edge_evt;
    logic         w_event;
    logic         w_load;
    logic         w_drop;
    logic         w_accept;

    ic_edge_detect #(
        .FILT (FILT)
    ) u_edge_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .ic_in    (ic_in),
        .edge_sel (edge_sel),
        .edge_evt (w_edge_evt)
    );

    assign w_event  = w_edge_evt & en;
    assign w_accept = r_cap_valid & cap_ready;
    // A held result blocks a new one unless it is accepted this same cycle.
    assign w_load   = w_event & (~r_cap_valid | cap_ready);
    assign w_drop   = w_event & r_cap_valid & ~cap_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tb         <= '0;
            r_last_ts    <= '0;
            r_have_prev  <= 1'b0;
            r_cap_valid  <= 1'b0;
            r_cap_val    <= '0;
            r_cap_period <= '0;
            r_cap_first  <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            if (en) begin
                r_tb <= r_tb + 1'b1;
            end

            // last_ts advances on every event, dropped ones included, so
            // the next period is always measured from the latest edge.
            if (w_event) begin
                r_last_ts <= r_tb;
            end

            if (w_load) begin
                r_cap_valid  <= 1'b1;
                r_cap_val    <= r_tb;
                r_cap_period <= r_tb - r_last_ts;
                r_cap_first  <= ~r_have_prev;
            end else if (w_accept) begin
                r_cap_valid  <= 1'b0;
            end

            // A disabled timebase breaks the period chain.
            if (!en) begin
                r_have_prev <= 1'b0;
            end else if (w_load) begin
                r_have_prev <= 1'b1;
            end

            // Drop wins over a coincident clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign cap_valid  = r_cap_valid;
    assign cap_val    = r_cap_val;
    assign cap_period = r_cap_period;
    assign cap_first  = r_cap_first;
    assign ovf        = r_ovf;
    assign tb_out     = r_tb;

endmodule
`default_nettype wire

// File: tb/tb_input_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_input_capture
//  Description : Self-checking bench for input_capture (N = 8, FILT = 3).
//                Table-driven pulse vectors, hand-written multi-cycle
//                sequences and a randomized run against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_capture;
    import input_capture_pkg::*;

    localparam int N    = 8;
    localparam int FILT = 3;
`ifdef IC_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
    localparam int LAT     = 2 + FILT;
`else
    localparam bit FILT_ON = 1'b0;
    localparam int LAT     = 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         ic_in;
    logic [1:0]   edge_sel;
    logic         cap_ready;
    logic         ovf_clr;
    logic         cap_valid;
    logic [N-1:0] cap_val;
    logic [N-1:0] cap_period;
    logic         cap_first;
    logic         ovf;
    logic [N-1:0] tb_out;

    input_capture #(.N(N), .FILT(FILT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ic_in      (ic_in),
        .edge_sel   (edge_sel),
        .cap_ready  (cap_ready),
        .ovf_clr    (ovf_clr),
        .cap_valid  (cap_valid),
        .cap_val    (cap_val),
        .cap_period (cap_period),
        .cap_first  (cap_first),
        .ovf        (ovf),
        .tb_out     (tb_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Accepted results, observed just before the clock edge that accepts them.
    typedef struct {
        logic [N-1:0] val;
        logic [N-1:0] per;
        logic         first;
    } cap_t;
    cap_t capq[$];

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && cap_valid === 1'b1 && cap_ready === 1'b1)
                capq.push_back('{val: cap_val, per: cap_period, first: cap_first});
        end
    end

    // Bench-side timebase: the tb_out value visible at the current negedge.
    int tnow = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (!rst_n)  tnow = 0;
            else if (en) tnow = (tnow + 1) % 256;
        end
    endtask

    task automatic do_reset(input logic ic_level);
        rst_n = 1'b0; ic_in = ic_level; en = 1'b1; ovf_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int t);
        for (int i = 0; i < 600 && tnow != t; i++) tick(1);
        check("run_until_tb_out", tb_out, t);
    endtask

    // Two rising edges gap cycles apart, first detected at timestamp t_cap.
    task automatic two_edges(input string name, input int t_cap, input int gap);
        int t1;
        t1 = (t_cap - LAT + 256) % 256;
        do_reset(1'b0);
        edge_sel = EDGE_RISE; cap_ready = 1'b1;
        run_until(t1);
        capq.delete();
        ic_in = 1'b1; tick(10);
        ic_in = 1'b0; tick(gap - 10);
        ic_in = 1'b1; tick(10);
        ic_in = 1'b0;
        check({name, "_count"}, capq.size(), 2);
        if (capq.size() == 2) begin
            check({name, "_val0"},   capq[0].val, t_cap % 256);
            check({name, "_first0"}, capq[0].first, 1);
            check({name, "_val1"},   capq[1].val, (t_cap + gap) % 256);
            check({name, "_per1"},   capq[1].per, gap);
            check({name, "_first1"}, capq[1].first, 0);
        end
    endtask

    // ---------------- reference model for the randomized run ----------------
    int           mm;
    bit           s1, s2, d1, d2, flt;
    bit           xq[$];
    logic [N-1:0] m_tb, m_last, m_val, m_per;
    bit           m_hp, m_cv, m_first, m_ovf;

    task automatic model_step(input bit r, input bit e, input bit i,
                              input bit [1:0] sel, input bit rdy, input bit clr);
        bit evt, drop, det, flip;
        if (!r) begin
            mm = 0; s1 = 0; s2 = 0; d1 = 0; d2 = 0; flt = 0; xq.delete();
            m_tb = 0; m_last = 0; m_val = 0; m_per = 0;
            m_hp = 0; m_cv = 0; m_first = 0; m_ovf = 0;
            return;
        end
        // Edge seen by the detector this cycle, after the warm-up window.
        evt  = (mm >= 3) && e && (d1 != d2) && ((sel[0] && d1) || (sel[1] && !d1));
        drop = 0;
        if (evt) begin
            if (!m_cv || rdy) begin
                m_val = m_tb; m_per = m_tb - m_last; m_first = !m_hp;
                m_cv = 1; m_hp = 1;
            end else begin
                drop = 1;
            end
            m_last = m_tb;
        end else if (m_cv && rdy) begin
            m_cv = 0;
        end
        if (clr)  m_ovf = 0;
        if (drop) m_ovf = 1;
        if (!e)   m_hp = 0;
        if (e)    m_tb = m_tb + 1;
        // Level presented to the detector after this edge.
        if (FILT_ON) begin
            xq.push_back(s2);
            if (xq.size() > FILT) void'(xq.pop_front());
            flip = (xq.size() == FILT);
            foreach (xq[k]) if (xq[k] == flt) flip = 0;
            if (flip) flt = !flt;
            det = flt;
        end else begin
            det = s1;
        end
        d2 = d1; d1 = det; s2 = s1; s1 = i;
        if (mm < 3) mm++;
    endtask

    // ---------------- table-driven pulse vectors ----------------
    typedef struct {
        logic [1:0] sel;
        int         width;
        int         exp_n;
        int         exp_per;
    } vec_t;
    vec_t vt[6];

    initial begin
        vt[0] = '{sel: EDGE_RISE, width: 7, exp_n: 1, exp_per: 0};
        vt[1] = '{sel: EDGE_FALL, width: 7, exp_n: 1, exp_per: 0};
        vt[2] = '{sel: EDGE_BOTH, width: 7, exp_n: 2, exp_per: 7};
        vt[3] = '{sel: EDGE_NONE, width: 7, exp_n: 0, exp_per: 0};
        vt[4] = '{sel: EDGE_RISE, width: 2, exp_n: FILT_ON ? 0 : 1, exp_per: 0};
        vt[5] = '{sel: EDGE_RISE, width: 4, exp_n: 1, exp_per: 0};

        rst_n = 1'b0; en = 1'b1; ic_in = 1'b0; edge_sel = EDGE_RISE;
        cap_ready = 1'b1; ovf_clr = 1'b0;
        @(negedge clk);
        tick(2);

        // Reset state.
        check("reset_outputs", {cap_valid, cap_val, cap_period, cap_first, ovf, tb_out}, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset(1'b0);
            edge_sel = vt[v].sel; cap_ready = 1'b1;
            run_until(10);
            capq.delete();
            ic_in = 1'b1; tick(vt[v].width);
            ic_in = 1'b0; tick(25);
            check($sformatf("vec%0d_count", v), capq.size(), vt[v].exp_n);
            if (capq.size() >= 1 && vt[v].exp_n >= 1) begin
                check($sformatf("vec%0d_val0", v), capq[0].val,
                      (vt[v].sel == EDGE_FALL) ? 10 + vt[v].width + LAT : 10 + LAT);
                check($sformatf("vec%0d_first0", v), capq[0].first, 1);
            end
            if (capq.size() >= 2 && vt[v].exp_n == 2) begin
                check($sformatf("vec%0d_val1", v), capq[1].val, 10 + vt[v].width + LAT);
                check($sformatf("vec%0d_per1", v), capq[1].per, vt[v].exp_per);
                check($sformatf("vec%0d_first1", v), capq[1].first, 0);
            end
        end

        // Two rising edges 50 cycles apart, and across the timebase wrap.
        two_edges("two_edges", 10, 50);
        two_edges("wrap", 250, 20);

        // Overflow: three edges with no consumer.
        do_reset(1'b0);
        edge_sel = EDGE_RISE; cap_ready = 1'b0;
        run_until(20);
        repeat (3) begin
            ic_in = 1'b1; tick(4);
            ic_in = 1'b0; tick(4);
        end
        tick(LAT);
        check("ovf_valid_held", cap_valid, 1);
        check("ovf_val_held",   cap_val, 20 + LAT);
        check("ovf_first_held", cap_first, 1);
        check("ovf_set",        ovf, 1);
        capq.delete();
        cap_ready = 1'b1; tick(1);
        cap_ready = 1'b0; tick(3);
        check("ovf_single_accept", capq.size(), 1);
        check("ovf_valid_after_accept", cap_valid, 0);
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1; tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Input high through reset release; then reset over a pending result.
        do_reset(1'b1);
        edge_sel = EDGE_RISE; cap_ready = 1'b1;
        capq.delete();
        tick(20);
`ifndef IC_GLITCH_FILTER_EN
        check("reset_high_no_capture", capq.size(), 0);
`endif
        cap_ready = 1'b0;
        ic_in = 1'b0; tick(6);
        ic_in = 1'b1; tick(LAT + 2);
        check("pending_before_reset", cap_valid, 1);
        rst_n = 1'b0; tick(1);
        check("reset_clears_pending", {cap_valid, cap_val, cap_period, cap_first, ovf, tb_out}, 0);
        rst_n = 1'b1; ic_in = 1'b0;

        // Randomized run against the reference model.
        en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst_n = (c < 2 || $urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 5) == 0) ic_in = ~ic_in;
            if (en) begin
                if ($urandom_range(0, 59) == 0) en = 1'b0;
            end else begin
                if ($urandom_range(0, 7) == 0) en = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) edge_sel = 2'($urandom_range(0, 3));
            cap_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            model_step(rst_n, en, ic_in, edge_sel, cap_ready, ovf_clr);
            @(posedge clk);
            #1;
            check($sformatf("rand_c%0d_valid", c), cap_valid, m_cv);
            if (cap_valid !== m_cv || cap_val !== m_val || cap_period !== m_per ||
                cap_first !== m_first || ovf !== m_ovf || tb_out !== m_tb)
                check($sformatf("rand_c%0d_outputs", c),
                      {cap_val, cap_period, cap_first, ovf, tb_out},
                      {m_val, m_per, m_first, m_ovf, m_tb});
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
